// File: rtl/mouse_device_sm.sv
// mouse_device_sm -- device-side PS/2 mouse responder.
// Decodes host command bytes and answers them with ack/self-test/ID bytes.
// When data reporting is on, it turns movement samples into 3-byte packets.
// Ports:
//   CLK, RESET                   clock, synchronous active-high reset
//   BYTE_READY/READ/ERROR_CODE   host byte from the device-side receiver
//   SEND_BYTE, BYTE_TO_SEND      one-cycle request plus byte to the transmitter
//   BYTE_SENT                    transmitter completion pulse
//   MOVE_VALID/READY/DX/DY/BUTTONS  movement sample handshake
//   STREAM_ENABLED               data reporting enabled
//   PACKET_SENT                  pulse after the third packet byte completes
module mouse_device_sm #(
  parameter int SELFTEST_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BYTE_READY,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  input  logic       MOVE_VALID,
  output logic       MOVE_READY,
  input  logic [8:0] MOVE_DX,
  input  logic [8:0] MOVE_DY,
  input  logic [2:0] MOVE_BUTTONS,
  output logic       STREAM_ENABLED,
  output logic       PACKET_SENT
);

  localparam int CW = $clog2(SELFTEST_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(SELFTEST_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_SENT, SELFTEST_WAIT} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      seq_reg [0:2];
  logic [7:0]      seq_next [0:2];
  logic [1:0]      idx_reg, idx_next;
  logic [1:0]      len_reg, len_next;
  logic            is_packet_reg, is_packet_next;
  logic            selftest_reg, selftest_next;
  logic            enable_on_ack_reg, enable_on_ack_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            pend_valid_reg, pend_valid_next;
  logic [7:0]      pend_byte_reg, pend_byte_next;
  logic [1:0]      pend_err_reg, pend_err_next;
  logic            stream_reg, stream_next;
  logic            send_byte_reg, send_byte_next;
  logic [7:0]      byte_reg, byte_next;
  logic            move_ready_reg, move_ready_next;
  logic            packet_sent_reg, packet_sent_next;

  logic            cmd_valid;
  logic [7:0]      cmd_byte;
  logic [1:0]      cmd_err;
  logic            accept;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg         <= IDLE;
      for (int i = 0; i < 3; i++) seq_reg[i] <= 8'h00;
      idx_reg           <= 2'd0;
      len_reg           <= 2'd0;
      is_packet_reg     <= 1'b0;
      selftest_reg      <= 1'b0;
      enable_on_ack_reg <= 1'b0;
      count_reg         <= '0;
      pend_valid_reg    <= 1'b0;
      pend_byte_reg     <= 8'h00;
      pend_err_reg      <= 2'b00;
      stream_reg        <= 1'b0;
      send_byte_reg     <= 1'b0;
      byte_reg          <= 8'h00;
      move_ready_reg    <= 1'b0;
      packet_sent_reg   <= 1'b0;
    end else begin
      state_reg         <= state_next;
      for (int i = 0; i < 3; i++) seq_reg[i] <= seq_next[i];
      idx_reg           <= idx_next;
      len_reg           <= len_next;
      is_packet_reg     <= is_packet_next;
      selftest_reg      <= selftest_next;
      enable_on_ack_reg <= enable_on_ack_next;
      count_reg         <= count_next;
      pend_valid_reg    <= pend_valid_next;
      pend_byte_reg     <= pend_byte_next;
      pend_err_reg      <= pend_err_next;
      stream_reg        <= stream_next;
      send_byte_reg     <= send_byte_next;
      byte_reg          <= byte_next;
      move_ready_reg    <= move_ready_next;
      packet_sent_reg   <= packet_sent_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next         = state_reg;
    for (int i = 0; i < 3; i++) seq_next[i] = seq_reg[i];
    idx_next           = idx_reg;
    len_next           = len_reg;
    is_packet_next     = is_packet_reg;
    selftest_next      = selftest_reg;
    enable_on_ack_next = enable_on_ack_reg;
    count_next         = count_reg;
    pend_valid_next    = pend_valid_reg;
    pend_byte_next     = pend_byte_reg;
    pend_err_next      = pend_err_reg;
    stream_next        = stream_reg;
    cmd_valid          = 1'b0;
    cmd_byte           = BYTE_READ;
    cmd_err            = BYTE_ERROR_CODE;
    accept             = 1'b0;

    // A host byte arriving while a byte is in flight is parked; a newer one
    // overwrites an older one.
    if ((state_reg == SEND || state_reg == WAIT_SENT) && BYTE_READY) begin
      pend_valid_next = 1'b1;
      pend_byte_next  = BYTE_READ;
      pend_err_next   = BYTE_ERROR_CODE;
    end

    case (state_reg)
      IDLE: begin
        if (BYTE_READY) begin
          cmd_valid = 1'b1;
        end else if (pend_valid_reg) begin
          cmd_valid = 1'b1;
          cmd_byte  = pend_byte_reg;
          cmd_err   = pend_err_reg;
        end else if (MOVE_VALID && move_ready_reg) begin
          accept = 1'b1;
        end
      end
      SEND: state_next = WAIT_SENT;
      WAIT_SENT: begin
        if (BYTE_SENT) begin
          if (enable_on_ack_reg) stream_next = 1'b1;
          if (pend_valid_reg || BYTE_READY) begin
            state_next = IDLE;  // abandon the rest; IDLE picks up the parked byte
          end else if (selftest_reg && idx_reg == 2'd0) begin
            state_next = SELFTEST_WAIT;
            idx_next   = 2'd1;
            count_next = '0;
          end else if (idx_reg + 2'd1 < len_reg) begin
            state_next = SEND;
            idx_next   = idx_reg + 2'd1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      SELFTEST_WAIT: begin
        // Nothing is on the wire here, so a host byte is handled at once.
        if (BYTE_READY) begin
          cmd_valid = 1'b1;
        end else if (count_reg == LAST_COUNT) begin
          state_next = SEND;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (cmd_valid) begin
      pend_valid_next    = 1'b0;
      state_next         = SEND;
      idx_next           = 2'd0;
      len_next           = 2'd1;
      count_next         = '0;
      is_packet_next     = 1'b0;
      selftest_next      = 1'b0;
      enable_on_ack_next = 1'b0;
      seq_next[0]        = 8'hFE;
      seq_next[1]        = 8'h00;
      seq_next[2]        = 8'h00;
      if (cmd_err == 2'b00) begin
        case (cmd_byte)
          8'hFF: begin
            stream_next   = 1'b0;
            seq_next[0]   = 8'hFA;
            seq_next[1]   = 8'hAA;
            len_next      = 2'd3;
            selftest_next = 1'b1;
          end
          8'hF4: begin
            seq_next[0]        = 8'hFA;
            enable_on_ack_next = 1'b1;
          end
          8'hF5: begin
            stream_next = 1'b0;
            seq_next[0] = 8'hFA;
          end
          8'hF2: begin
            seq_next[0] = 8'hFA;
            len_next    = 2'd2;
          end
          default: ;
        endcase
      end
    end

    if (accept) begin
      state_next         = SEND;
      idx_next           = 2'd0;
      len_next           = 2'd3;
      is_packet_next     = 1'b1;
      selftest_next      = 1'b0;
      enable_on_ack_next = 1'b0;
      // Overflow bits stay 0: the 9-bit inputs always fit the packet format.
      seq_next[0] = {2'b00, MOVE_DY[8], MOVE_DX[8], 1'b1, MOVE_BUTTONS};
      seq_next[1] = MOVE_DX[7:0];
      seq_next[2] = MOVE_DY[7:0];
    end
  end

  // Output logic (next values of the output registers)
  always_comb begin
    send_byte_next   = (state_reg == SEND);
    byte_next        = (state_reg == SEND) ? seq_reg[idx_reg] : byte_reg;
    packet_sent_next = (state_reg == WAIT_SENT) && BYTE_SENT && is_packet_reg &&
                       (idx_reg == 2'd2);
    move_ready_next  = (state_next == IDLE) && stream_next && !pend_valid_next;
  end

  assign SEND_BYTE      = send_byte_reg;
  assign BYTE_TO_SEND   = byte_reg;
  assign STREAM_ENABLED = stream_reg;
  assign PACKET_SENT    = packet_sent_reg;
  // A command in the same cycle takes priority over a movement sample.
  assign MOVE_READY     = move_ready_reg & ~BYTE_READY;

endmodule
